// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
package mips_cpu_hilo_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } hilo_state_t;

endpackage

// File: rtl/mips_cpu_hilo_iter.sv
// One iteration of the HI/LO datapath: a shift-add multiply step or a
// restoring divide step over a 2*WIDTH accumulator.
//   multiply: acc = {partial product, remaining multiplier bits}, opnd = multiplicand
//   divide  : acc = {partial remainder, dividend/quotient bits},  opnd = divisor
module mips_cpu_hilo_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  // Compute the next accumulator value for the selected operation.
  always_comb begin
    sum_s    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    // Remainder shifted left by one with the next dividend bit brought in.
    rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
    // A set top bit means the trial subtraction went negative (restore).
    diff_s   = rem_sh_s - {1'b0, opnd_i};
    acc_o    = {(2*WIDTH){1'b0}};
    if (is_div_i) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {sum_s, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mips_cpu_hilo_seq.sv
// HI/LO sequencer: iterative MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO,
// owner of the HI and LO registers and source of the mul/div stall.
// Results go through a one-cycle writeback register so that hi/lo and the
// done pulse change together, one cycle after FIXUP.
module mips_cpu_hilo_seq #(
  parameter int WIDTH = mips_cpu_hilo_pkg::WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mf_req,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mips_cpu_hilo_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Magnitude of a value, treated as two's complement only when sgn is set.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      abs_val = -v;
    end else begin
      abs_val = v;
    end
  endfunction

  hilo_state_t        state_q, state_d;
  hilo_op_t           op_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step_s;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               wb_q, wb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sgn_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  assign op_s = hilo_op_t'(op);

  mips_cpu_hilo_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step_s)
  );

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod_s = neg_lo_q ? -acc_q : acc_q;
    quo_s  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // FSM next state, operand capture, iteration and HI/LO update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wb_d     = 1'b0;
    done_d   = wb_q;
    sgn_s    = 1'b0;
    if (wb_q) begin
      hi_d = res_hi_q;
      lo_d = res_lo_q;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_s)
            MTHI: hi_d = rs_data;
            MTLO: lo_d = rs_data;
            MULT, MULTU: begin
              sgn_s    = (op_s == MULT);
              acc_d    = {{WIDTH{1'b0}}, abs_val(rt_data, sgn_s)};
              opnd_d   = abs_val(rs_data, sgn_s);
              is_div_d = 1'b0;
              neg_lo_d = sgn_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              neg_hi_d = sgn_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
              cnt_d    = CNT_LAST;
              state_d  = CALC;
            end
            DIV, DIVU: begin
              sgn_s    = (op_s == DIV);
              is_div_d = 1'b1;
              if (rt_data == {WIDTH{1'b0}}) begin
                // Divide by zero: the pass-through result goes straight to FIXUP.
                acc_d    = {rs_data, {WIDTH{1'b1}}};
                opnd_d   = {WIDTH{1'b0}};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                cnt_d    = {CNT_W{1'b0}};
                state_d  = FIXUP;
              end else begin
                acc_d    = {{WIDTH{1'b0}}, abs_val(rs_data, sgn_s)};
                opnd_d   = abs_val(rt_data, sgn_s);
                neg_lo_d = sgn_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                neg_hi_d = sgn_s & rs_data[WIDTH-1];
                cnt_d    = CNT_LAST;
                state_d  = CALC;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_step_s;
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIXUP: begin
        if (is_div_q) begin
          res_hi_d = rem_s;
          res_lo_d = quo_s;
        end else begin
          res_hi_d = prod_s[2*WIDTH-1:WIDTH];
          res_lo_d = prod_s[WIDTH-1:0];
        end
        wb_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      res_hi_q <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      wb_q     <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wb_q     <= wb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign stall = busy_q & (start | mf_req);
  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_seq.sv
// Directed bench for the HI/LO sequencer with hand-computed expectations.
module tb_mips_cpu_hilo_seq;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mf_req;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;
  int done_edge;
  int busy_cyc;
  int done_cnt;

  mips_cpu_hilo_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mf_req  (mf_req),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op (start sampled at edge 0) and wait, bounded, for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int d_edge, output int b_cyc);
    op = o;
    rs_data = a;
    rt_data = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b_cyc = 0;
    d_edge = -1;
    if (busy === 1'b1) b_cyc++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) b_cyc++;
      if (done === 1'b1) begin
        d_edge = k;
        break;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start = 1'b0;
    op = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    mf_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1. MULTU max * max
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, done_edge, busy_cyc);
    chk("multu_done_edge", 32'(done_edge), 32'd34);
    chk("multu_busy_cycles", 32'(busy_cyc), 32'd33);
    chk("multu_busy_at_done", {31'd0, busy}, 32'd0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    @(posedge clk); #1;
    chk("done_pulse_width", {31'd0, done}, 32'd0);

    // 2. MULT -3 * 7
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, done_edge, busy_cyc);
    chk("mult_done_edge", 32'(done_edge), 32'd34);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    // 3. Divides
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, done_edge, busy_cyc);
    chk("div_neg_done_edge", 32'(done_edge), 32'd34);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(OP_DIVU, 32'd7, 32'd2, done_edge, busy_cyc);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, done_edge, busy_cyc);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);
    run_op(OP_MULTU, 32'h00010000, 32'h00030000, done_edge, busy_cyc);
    chk("multu_mid_hi", hi, 32'h00000003);
    chk("multu_mid_lo", lo, 32'd0);

    // 4. Divide by zero
    run_op(OP_DIV, 32'h12345678, 32'd0, done_edge, busy_cyc);
    chk("div0_done_edge", 32'(done_edge), 32'd2);
    chk("div0_busy_cycles", 32'(busy_cyc), 32'd1);
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'hFFFFFFFF);

    // 5a. mf_req and a second start while busy
    op = OP_MULTU;
    rs_data = 32'd3;
    rt_data = 32'd5;
    start = 1'b1;
    @(posedge clk); #1;
    op = OP_MTHI;
    rs_data = 32'hAAAAAAAA;
    mf_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("busy_stall", {31'd0, stall}, 32'd1);
      chk("busy_hi_hold", hi, 32'h12345678);
      chk("busy_lo_hold", lo, 32'hFFFFFFFF);
    end
    start = 1'b0;
    mf_req = 1'b0;
    done_edge = -1;
    for (int k = 6; k <= 45; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_edge = k;
        break;
      end
    end
    chk("busy_op_done_edge", 32'(done_edge), 32'd34);
    chk("busy_op_hi", hi, 32'd0);
    chk("busy_op_lo", lo, 32'd15);

    // 5b. idle access
    @(posedge clk); #1;
    mf_req = 1'b1;
    #1;
    chk("idle_mf_stall", {31'd0, stall}, 32'd0);
    mf_req = 1'b0;
    op = OP_MTHI;
    rs_data = 32'hDEADBEEF;
    start = 1'b1;
    #1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'd15);
    chk("mthi_done", {31'd0, done}, 32'd0);
    op = OP_MTLO;
    rs_data = 32'h0BADF00D;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h0BADF00D);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // 6. reset in the middle of CALC
    op = OP_MULTU;
    rs_data = 32'hFFFFFFFF;
    rt_data = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("calc_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_hi_after", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
